// File: rtl/fifo_flags_pkg.sv
// Shared FIFO sizing helpers and default thresholds, reused by fifo_flags and
// future multi-channel FIFOs.
package fifo_flags_pkg;

  localparam int DEF_B      = 8;
  localparam int DEF_W      = 2;
  localparam int DEF_AE_LVL = 1;

  // Depth in words for a given address width.
  function automatic int fifo_depth(input int w);
    return 1 << w;
  endfunction

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int count_bits(input int w);
    return w + 1;
  endfunction

  // Default almost-full level: one word short of full.
  function automatic int def_af_lvl(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module fifo_regfile #(
  parameter int B = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic [W-1:0] r_addr,
  output logic [B-1:0] r_data
);

  logic [B-1:0] mem [2**W];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_flags.sv
// Show-ahead FIFO with occupancy count, almost-full/empty thresholds, sticky
// overflow/underflow flags and synchronous flush.
module fifo_flags
  import fifo_flags_pkg::*;
#(
  parameter int B      = DEF_B,
  parameter int W      = DEF_W,
  parameter int AF_LVL = def_af_lvl(W),
  parameter int AE_LVL = DEF_AE_LVL
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam int CW = count_bits(W);
  localparam logic [W:0] DEPTH_C = CW'(fifo_depth(W));
  localparam logic [W:0] AF_C    = CW'(AF_LVL);
  localparam logic [W:0] AE_C    = CW'(AE_LVL);

  logic [W-1:0] w_ptr, r_ptr;
  logic         rd_acc, wr_acc;
  logic [W:0]   count_nxt;

  // Handshake: wr/rd are requests sampled every edge; a request is accepted
  // only when the queue can honour it, otherwise it is dropped and the
  // matching sticky error flag records the attempt. A full queue still takes
  // a write when a read frees a slot in the same cycle.
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd_acc);

  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc)      count_nxt = count + 1'b1;
    else if (rd_acc && !wr_acc) count_nxt = count - 1'b1;
  end

  fifo_regfile #(.B(B), .W(W)) u_regfile (
    .clk    (clk),
    .we     (wr_acc & ~flush),
    .w_addr (w_ptr),
    .w_data (w_data),
    .r_addr (r_ptr),
    .r_data (r_data)
  );

  // Flags are computed from the next count so they always agree with count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (flush) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + 1'b1;
      if (rd_acc) r_ptr <= r_ptr + 1'b1;
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == DEPTH_C);
      almost_empty <= (count_nxt <= AE_C);
      almost_full  <= (count_nxt >= AF_C);
      overflow     <= overflow  | (wr & ~wr_acc);
      underflow    <= underflow | (rd & empty);
    end
  end

endmodule

// File: tb/tb_fifo_flags.sv
// Directed bench for fifo_flags: queue-based reference model checked every
// cycle, plus literal expectations along each scenario.
module tb_fifo_flags;

  localparam int B     = 8;
  localparam int W     = 2;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush, wr, rd;
  logic [B-1:0] w_data;
  logic [B-1:0] r_data;
  logic         empty, full, almost_empty, almost_full, overflow, underflow;
  logic [W:0]   count;

  int vectors = 0;
  int miscompares = 0;

  fifo_flags #(.B(B), .W(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .wr           (wr),
    .w_data       (w_data),
    .rd           (rd),
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [B-1:0] exp_q[$];
  bit           m_ovf, m_udf;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (flush) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      bit take_rd, take_wr;
      take_rd = rd && (exp_q.size() > 0);
      take_wr = wr && ((exp_q.size() < DEPTH) || take_rd);
      if (rd && exp_q.size() == 0) m_udf = 1'b1;
      if (wr && !take_wr) m_ovf = 1'b1;
      if (take_rd) void'(exp_q.pop_front());
      if (take_wr) exp_q.push_back(w_data);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int n;
    n = exp_q.size();
    check("mdl_count", 32'(count), 32'(n));
    check("mdl_empty", 32'(empty), 32'(n == 0));
    check("mdl_full", 32'(full), 32'(n == DEPTH));
    check("mdl_almost_empty", 32'(almost_empty), 32'(n <= 1));
    check("mdl_almost_full", 32'(almost_full), 32'(n >= DEPTH - 1));
    check("mdl_overflow", 32'(overflow), 32'(m_ovf));
    check("mdl_underflow", 32'(underflow), 32'(m_udf));
    if (n > 0) check("mdl_r_data", 32'(r_data), 32'(exp_q[0]));
  end

  // ---------------- driver ----------------
  // Apply one cycle of inputs; returns at the following negedge.
  task automatic tick(input logic w, input logic [B-1:0] d, input logic r, input logic f);
    wr = w; w_data = d; rd = r; flush = f;
    @(negedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0; w_data = '0;
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;

    // 1: reset asserted mid-operation acts without a clock edge
    tick(1'b1, 8'hE1, 1'b0, 1'b0);
    tick(1'b1, 8'hE2, 1'b0, 1'b0);
    check("pre_reset_count", 32'(count), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_almost_empty", 32'(almost_empty), 32'd1);
    check("rst_almost_full", 32'(almost_full), 32'd0);
    check("rst_ovf_udf", 32'({overflow, underflow}), 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;

    // 2: fill, overflow, drain in order
    tick(1'b1, 8'h11, 1'b0, 1'b0);
    check("fill1_count", 32'(count), 32'd1);
    check("fill1_r_data", 32'(r_data), 32'h11);
    tick(1'b1, 8'h22, 1'b0, 1'b0);
    check("fill2_af", 32'(almost_full), 32'd0);
    tick(1'b1, 8'h33, 1'b0, 1'b0);
    check("fill3_af", 32'(almost_full), 32'd1);
    check("fill3_full", 32'(full), 32'd0);
    tick(1'b1, 8'h44, 1'b0, 1'b0);
    check("fill4_full", 32'(full), 32'd1);
    tick(1'b1, 8'h55, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      logic [B-1:0] e;
      e = 8'((i + 1) * 8'h11);
      check("drain_r_data", 32'(r_data), 32'(e));
      tick(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drain_empty", 32'(empty), 32'd1);

    // 3: empty with simultaneous rd/wr
    tick(1'b1, 8'hA5, 1'b1, 1'b0);
    check("e_rw_count", 32'(count), 32'd1);
    check("e_rw_udf", 32'(underflow), 32'd1);
    check("e_rw_r_data", 32'(r_data), 32'hA5);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    check("flush_clear", 32'({overflow, underflow, empty}), 32'b001);

    // 4: full with simultaneous rd/wr
    for (int i = 1; i <= 4; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
    tick(1'b1, 8'h05, 1'b1, 1'b0);
    check("f_rw_count", 32'(count), 32'd4);
    check("f_rw_full", 32'(full), 32'd1);
    check("f_rw_ovf", 32'(overflow), 32'd0);
    for (int i = 2; i <= 5; i++) begin
      check("f_rw_drain", 32'(r_data), 32'(i));
      tick(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // 5: pointer wrap with interleaved single write/read
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 8'(i), 1'b0, 1'b0);
      check("wrap_r_data", 32'(r_data), 32'(i));
      check("wrap_count1", 32'(count), 32'd1);
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      check("wrap_count0", 32'({full, count}), 32'd0);
    end

    // 6: flush beats a same-cycle write
    for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_flush_count", 32'(count), 32'd3);
    check("pre_flush_ovf", 32'(overflow), 32'd1);
    tick(1'b1, 8'h77, 1'b0, 1'b1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_ovf", 32'(overflow), 32'd0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    check("flush_no_write", 32'(count), 32'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
